data_memory_arbiter: RTL and testbench

//  Two-master round-robin arbiter in front of the single-port on-chip data RAM
//  (13-bit word address, 32-bit data, 4 byte enables).

---
 rtl/data_memory_arbiter_pkg.sv | 22 ++
 rtl/data_memory_arbiter_rr_arbiter2.sv | 43 ++++
 rtl/data_memory_arbiter.sv | 112 +++++++++++
 tb/tb_data_memory_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// rtl/data_memory_arbiter_pkg.sv - shared widths, master ids and command struct
// Ports: none (package).
package data_memory_arbiter_pkg;

  localparam int DMA_ADDR_W = 13;
  localparam int DMA_DATA_W = 32;
  localparam int DMA_BE_W   = DMA_DATA_W / 8;

  // Master-id encoding used on the grant and in the read-return pipeline
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // One Avalon-MM command as presented by a master
  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_BE_W-1:0]   be;
    logic [DMA_DATA_W-1:0] wdata;
    logic                  rd;
    logic                  wr;
  } avmm_cmd_t;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// rtl/data_memory_arbiter_rr_arbiter2.sv - two-requester round-robin grant with last_grant register
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           grant enable (low blocks every grant)
//   req[1:0]     request per master
//   grant_valid  a master is granted this cycle
//   grant_id     granted master id (meaningful when grant_valid)
module rr_arbiter2
  import data_memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic       grant_valid,
  output logic       grant_id
);

  logic last_grant;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = M0;
    if (en) begin
      case (req)
        2'b01: begin grant_valid = 1'b1; grant_id = M0;          end
        2'b10: begin grant_valid = 1'b1; grant_id = M1;          end
        2'b11: begin grant_valid = 1'b1; grant_id = ~last_grant; end
        default: ;
      endcase
    end
  end

  // Resetting to M1 makes master 0 win the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= M1;
    end else if (grant_valid) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-master round-robin front end for the single-port data RAM
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   reset_req               gates RAM clock enable and blocks new grants
//   m0_* / m1_*             Avalon-MM slave ports of the two masters
//   ram_*                   pipelined master port to the RAM (ram_readdata is q)
// Read data returns READ_LATENCY (1..2) cycles after acceptance, in issue order.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DMA_ADDR_W,
  parameter int DATA_W       = DMA_DATA_W,
  parameter int READ_LATENCY = 1,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  avmm_cmd_t cmd0, cmd1, sel;
  logic      grant_valid, grant_id;
  logic      read_accept;

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_id;
  logic                    tail_valid, tail_id;

  assign ram_clken = ~reset_req;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (reset),
    .en          (~reset_req & ~reset),
    .req         ({m1_read | m1_write, m0_read | m0_write}),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    cmd0 = '{addr:  DMA_ADDR_W'(m0_address),  be: DMA_BE_W'(m0_byteenable),
             wdata: DMA_DATA_W'(m0_writedata), rd: m0_read, wr: m0_write};
    cmd1 = '{addr:  DMA_ADDR_W'(m1_address),  be: DMA_BE_W'(m1_byteenable),
             wdata: DMA_DATA_W'(m1_writedata), rd: m1_read, wr: m1_write};
    sel  = '0;
    if (grant_valid) begin
      sel = (grant_id == M1) ? cmd1 : cmd0;
    end
  end

  assign m0_waitrequest = ~(grant_valid & (grant_id == M0));
  assign m1_waitrequest = ~(grant_valid & (grant_id == M1));

  // With no grant sel is all-zero, so every ram_* output idles at 0
  assign ram_chipselect = grant_valid;
  assign ram_address    = ADDR_W'(sel.addr);
  assign ram_byteenable = BE_W'(sel.be);
  assign ram_writedata  = DATA_W'(sel.wdata);
  assign ram_write      = sel.wr;

  // Read together with write is a write only: no read return is tracked
  assign read_accept = grant_valid & sel.rd & ~sel.wr;

  // Read-return pipeline frozen with the RAM while ram_clken is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_id    <= '0;
    end else if (ram_clken) begin
      pipe_valid[0] <= read_accept;
      pipe_id[0]    <= grant_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  assign tail_valid = pipe_valid[READ_LATENCY-1];
  assign tail_id    = pipe_id[READ_LATENCY-1];

  // A held tail entry is presented only on the cycle the pipeline advances,
  // so a read stalled by reset_req is delivered exactly once
  assign m0_readdatavalid = tail_valid & ram_clken & (tail_id == M0);
  assign m1_readdatavalid = tail_valid & ram_clken & (tail_id == M1);
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset, reset_req;
  logic [12:0] m0_address, m1_address, ram_address;
  logic [3:0]  m0_byteenable, m1_byteenable, ram_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, ram_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_readdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(13), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  // RAM model: registered address, unregistered q, read-during-write gives old data
  always @(posedge clk) begin
    if (ram_clken) begin
      ram_readdata <= mem[ram_address];
      if (ram_chipselect && ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
      end
    end
  end

  task automatic idle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1; idle();
    @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; m0_read = 1; m0_address = 13'h0005; m1_write = 1;
    #1;
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait got %b exp 1", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m1_wait got %b exp 1", m1_waitrequest); end
    checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b exp 0", ram_chipselect); end
    checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL rst_ram_write got %b exp 0", ram_write); end
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rst_rdv got %b exp 00", {m0_readdatavalid, m1_readdatavalid}); end
    idle();
    @(negedge clk); reset = 0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m0_read = 1; m0_address = 13'h0005; m0_byteenable = 4'hF;
    #1;
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL sr_m0_wait got %b exp 0", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL sr_m1_wait got %b exp 1", m1_waitrequest); end
    checks++; if (ram_chipselect !== 1'b1 || ram_write !== 1'b0 || ram_address !== 13'h0005) begin
      errors++; $display("FAIL sr_ram_cmd got cs=%b wr=%b a=%h exp cs=1 wr=0 a=0005", ram_chipselect, ram_write, ram_address); end
    @(negedge clk); idle(); #1;
    checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL sr_m0_rdv got %b exp 1", m0_readdatavalid); end
    checks++; if (m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_m0_data got %h exp deadbeef", m0_readdata); end
    checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_m1_rdv got %b exp 0", m1_readdatavalid); end
    @(negedge clk); #1;
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_m0_rdv_once got %b exp 0", m0_readdatavalid); end
  endtask

  task automatic test_alternation();
    logic exp0;
    pulse_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 6) begin
        m0_read = 1; m0_address = 13'h0010; m1_read = 1; m1_address = 13'h0020;
      end else idle();
      #1;
      if (c < 6) begin
        checks++; if (m0_waitrequest !== (c % 2 == 1)) begin errors++; $display("FAIL alt_m0_wait c=%0d got %b", c, m0_waitrequest); end
        checks++; if (m1_waitrequest !== (c % 2 == 0)) begin errors++; $display("FAIL alt_m1_wait c=%0d got %b", c, m1_waitrequest); end
      end
      if (c >= 1) begin
        exp0 = ((c - 1) % 2 == 0);
        checks++; if (m0_readdatavalid !== exp0 || m1_readdatavalid !== !exp0) begin
          errors++; $display("FAIL alt_rdv c=%0d got %b%b exp %b%b", c, m0_readdatavalid, m1_readdatavalid, exp0, !exp0); end
        checks++; if (m0_readdata !== (exp0 ? 32'h000000A0 : 32'h000000B1)) begin
          errors++; $display("FAIL alt_data c=%0d got %h exp %h", c, m0_readdata, exp0 ? 32'h000000A0 : 32'h000000B1); end
      end
    end
  endtask

  task automatic test_write_readback();
    @(negedge clk);
    m1_write = 1; m1_address = 13'h1FFF; m1_byteenable = 4'b0011; m1_writedata = 32'h12345678;
    #1;
    checks++; if (m1_waitrequest !== 1'b0 || ram_write !== 1'b1 || ram_address !== 13'h1FFF
                  || ram_byteenable !== 4'b0011 || ram_writedata !== 32'h12345678) begin
      errors++; $display("FAIL wr_cmd got w=%b wr=%b a=%h be=%b d=%h", m1_waitrequest, ram_write, ram_address, ram_byteenable, ram_writedata); end
    @(negedge clk); idle();
    m1_read = 1; m1_address = 13'h1FFF; m1_byteenable = 4'hF;
    #1;
    checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL wr_no_rdv got %b exp 0", m1_readdatavalid); end
    @(negedge clk); idle(); #1;
    checks++; if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL wr_rb_rdv got m1=%b m0=%b exp 1 0", m1_readdatavalid, m0_readdatavalid); end
    checks++; if (m1_readdata !== 32'hAABB5678) begin errors++; $display("FAIL wr_rb_data got %h exp aabb5678", m1_readdata); end
  endtask

  task automatic test_reset_req();
    @(negedge clk);
    m0_read = 1; m0_address = 13'h0005;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reset_req = 1; m0_read = 1; m0_address = 13'h0010; m1_read = 1; m1_address = 13'h0020;
      #1;
      checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || ram_chipselect !== 1'b0 || ram_clken !== 1'b0) begin
        errors++; $display("FAIL rr_hold c=%0d got w0=%b w1=%b cs=%b ce=%b", c, m0_waitrequest, m1_waitrequest, ram_chipselect, ram_clken); end
      checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
        errors++; $display("FAIL rr_rdv_held c=%0d got %b%b exp 00", c, m0_readdatavalid, m1_readdatavalid); end
    end
    @(negedge clk); reset_req = 0; idle(); #1;
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rr_release got v0=%b d=%h v1=%b exp 1 deadbeef 0", m0_readdatavalid, m0_readdata, m1_readdatavalid); end
    @(negedge clk); #1;
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rr_once got %b exp 0", m0_readdatavalid); end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk); m1_read = 1; m1_address = 13'h0020;
    @(negedge clk); idle(); m0_read = 1; m0_address = 13'h0010;
    #1;
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL ri_m0_grant got %b exp 0", m0_waitrequest); end
    @(negedge clk);
    reset = 1; m0_read = 1; m0_address = 13'h0010; m1_read = 1; m1_address = 13'h0020;
    #1;
    checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL ri_rdv got %b%b exp 00", m0_readdatavalid, m1_readdatavalid); end
    checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || ram_chipselect !== 1'b0 || ram_write !== 1'b0) begin
      errors++; $display("FAIL ri_outs got w0=%b w1=%b cs=%b wr=%b", m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write); end
    @(negedge clk); reset = 0; #1;
    checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL ri_first_grant got w0=%b w1=%b exp 0 1", m0_waitrequest, m1_waitrequest); end
    checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL ri_dropped got %b%b exp 00", m0_readdatavalid, m1_readdatavalid); end
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  task automatic test_read_write_together();
    @(negedge clk);
    m0_read = 1; m0_write = 1; m0_address = 13'h0030; m0_byteenable = 4'hF; m0_writedata = 32'hCAFEF00D;
    #1;
    checks++; if (m0_waitrequest !== 1'b0 || ram_chipselect !== 1'b1 || ram_write !== 1'b1 || ram_writedata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rw_cmd got w0=%b cs=%b wr=%b d=%h", m0_waitrequest, ram_chipselect, ram_write, ram_writedata); end
    @(negedge clk); idle(); #1;
    checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rw_no_rdv got %b%b exp 00", m0_readdatavalid, m1_readdatavalid); end
    @(negedge clk); m0_read = 1; m0_address = 13'h0030; m0_byteenable = 4'hF;
    @(negedge clk); idle(); #1;
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rw_readback got v=%b d=%h exp 1 cafef00d", m0_readdatavalid, m0_readdata); end
  endtask

  initial begin
    reset = 1; reset_req = 0; idle();
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[13'h0005] = 32'hDEADBEEF;
    mem[13'h0010] = 32'h000000A0;
    mem[13'h0020] = 32'h000000B1;
    mem[13'h1FFF] = 32'hAABBCCDD;
    test_reset();
    test_single_read();
    test_alternation();
    test_write_readback();
    test_reset_req();
    test_reset_inflight();
    test_read_write_together();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
